sd_card_cmd_responder: RTL
==========================

SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset, with ports named as below.
REQ-002 Parameter NCR, default 2, is the number of idle cycles between the end of the command check cycle and the response start bit (legal range 2..64).
REQ-003 sd_clock  input  1  sole clock; all state changes and cmd_in sampling occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_in  input  1  CMD line value from the pad; the line idles high.
REQ-006 cmd_out  output  1  CMD value driven toward the pad.
REQ-007 cmd_oe  output  1  pad output enable; 1 means drive cmd_out.
REQ-008 resp_status  input  32  card status placed in the R1 response.
REQ-009 cmd_valid  output  1  one-cycle pulse marking a frame that was accepted.
REQ-010 cmd_index  output  6  index of the last accepted command.
REQ-011 cmd_argument  output  32  argument of the last accepted command.
REQ-012 crc_error  output  1  one-cycle pulse marking a rejected frame.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, RECV, CHECK, WAIT_NCR and SEND.
REQ-015 In IDLE, when cmd_in is sampled 0 at edge S, the FSM SHALL enter RECV and the start bit SHALL be stored as frame bit 47.
REQ-016 In RECV, the FSM SHALL shift frame bits 46..0 (MSB first) on edges S+1..S+47; at edge S+48 it SHALL enter CHECK.
REQ-017 CHECK SHALL last exactly one cycle and SHALL accept the frame only if all of the following hold:
- bit 46 (transmission bit) == 1
- bit 0 (end bit) == 1
- bits 7..1 == CRC7 (x^7+x^3+1, initial value 0) computed over bits 47..8
REQ-018 On accept, during the CHECK cycle:
- cmd_valid = 1
- cmd_index = bits 45..40 and cmd_argument = bits 39..8, both held until the next accept
- resp_status is sampled
- the FSM enters WAIT_NCR
REQ-019 On reject, during the CHECK cycle crc_error = 1, outputs are unchanged, and the FSM returns to IDLE.
REQ-020 WAIT_NCR SHALL last NCR cycles with cmd_oe = 0; the FSM then enters SEND.
REQ-021 SEND SHALL drive 48 bits, MSB first, one per cycle, with cmd_oe = 1:
- start bit 0
- transmission bit 0
- echoed cmd_index
- sampled status (32 bits)
- CRC7 over the preceding 40 bits
- end bit 1
REQ-022 After the 48th bit, the FSM SHALL return to IDLE, and on that edge cmd_oe = 0 and cmd_out = 1.
REQ-023 Whenever cmd_oe = 0, cmd_out SHALL be 1.
REQ-024 cmd_in SHALL be ignored in CHECK, WAIT_NCR and SEND.
REQ-025 A frame with transmission bit 0 (host echo or another card's response) SHALL be rejected with crc_error = 1, and SHALL NOT produce a response.
REQ-026 A new start bit sampled in the same cycle the FSM returns to IDLE SHALL NOT be captured; capture begins from IDLE only.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE, and the outputs SHALL take these values:
- cmd_oe = 0, cmd_out = 1
- cmd_valid = 0, crc_error = 0, busy = 0
- cmd_index = 0, cmd_argument = 0
- bit counter and shift register = 0
REQ-028 Reset asserted mid-RECV or mid-SEND SHALL take effect on the next edge, releasing the line (cmd_oe = 0) on that edge.

Configuration
REQ-029 With CMD_CRC_CHECK_EN defined, CHECK SHALL enforce the CRC7 condition of REQ-017.
REQ-030 Without CMD_CRC_CHECK_EN, the received CRC field SHALL be ignored: only the transmission and end bits gate acceptance, crc_error fires only on those failures, and response CRC7 generation is unchanged.

Verification
REQ-031 Frame 0x40_00000000_95 (CMD0), NCR = 2 -> cmd_valid pulse one edge after the end bit with cmd_index = 0 and cmd_argument = 0; cmd_oe rises 3 edges after the cmd_valid edge and stays high 48 cycles.
REQ-032 Frame 0x77_00000000_65 (CMD55) with resp_status = 0x00000120 -> response bits equal 0x37_00000120_83.
REQ-033 Frame 0x48_000001AA_87 (CMD8) -> cmd_index = 8 and cmd_argument = 0x000001AA; the response echoes index 8.
REQ-034 Frame 0x40_00000000_97 (bad CRC):
- with CMD_CRC_CHECK_EN -> crc_error pulse, no cmd_valid, cmd_oe stays 0
- without the macro -> accepted and a response is sent
REQ-035 Frame 0x00_00000000_xx (transmission bit 0) -> crc_error pulse, cmd_index and cmd_argument unchanged, no response.
REQ-036 Reset asserted at the 20th SEND bit -> next edge cmd_oe = 0, cmd_out = 1, busy = 0; a following valid CMD0 is accepted normally.

Source files
------------

// File: rtl/sd_card_cmd_responder_if.sv
// CMD-line and command/status bus between the SD command responder and its surroundings.
interface sd_card_cmd_responder_if;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic [31:0] resp_status;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        crc_error;
    logic        busy;

    modport slave (
        input  cmd_in, resp_status,
        output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_argument, crc_error, busy
    );

    modport master (
        output cmd_in, resp_status,
        input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_argument, crc_error, busy
    );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit command frames, validates them and answers with an R1 frame.
// Optional macro CMD_CRC_CHECK_EN: when defined, the received CRC7 must match for a frame to be accepted.
module sd_card_cmd_responder #(
    parameter int unsigned NCR = 2
) (
    input  logic                   sd_clock,
    input  logic                   reset,
    sd_card_cmd_responder_if.slave bus
);
    localparam int unsigned FRAME_W   = 48;
    localparam int unsigned PAYLOAD_W = 40;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned ARG_W     = 32;

    typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT_NCR, SEND} state_t;

    state_t             state, state_d;
    logic [FRAME_W-1:0] shreg, shreg_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic               cmd_out_q, cmd_out_d;
    logic               cmd_oe_q, cmd_oe_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               crc_error_q, crc_error_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   cmd_index_q, cmd_index_d;
    logic [ARG_W-1:0]   cmd_argument_q, cmd_argument_d;

    logic                 crc_ok_c;
    logic                 frame_ok_c;
    logic [PAYLOAD_W-1:0] resp_payload_c;
    logic [FRAME_W-1:0]   resp_frame_c;

    // CRC7 (x^7 + x^3 + 1), zero seed, MSB first
    function automatic logic [CRC_W-1:0] crc7(input logic [PAYLOAD_W-1:0] data);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = '0;
        for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
            fb  = data[i] ^ crc[CRC_W-1];
            crc = {crc[CRC_W-2:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction

`ifdef CMD_CRC_CHECK_EN
    assign crc_ok_c = (shreg[CRC_W:1] == crc7(shreg[FRAME_W-1:CRC_W+1]));
`else
    assign crc_ok_c = 1'b1;
`endif

    // Frame accepted only with transmission bit set, end bit set and (optionally) matching CRC
    assign frame_ok_c     = shreg[FRAME_W-2] & shreg[0] & crc_ok_c;
    assign resp_payload_c = {2'b00, shreg[45:40], bus.resp_status};
    assign resp_frame_c   = {resp_payload_c, crc7(resp_payload_c), 1'b1};

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            cmd_out_q      <= 1'b1;
            cmd_oe_q       <= 1'b0;
            cmd_valid_q    <= 1'b0;
            crc_error_q    <= 1'b0;
            busy_q         <= 1'b0;
            cmd_index_q    <= '0;
            cmd_argument_q <= '0;
        end else begin
            state          <= state_d;
            shreg          <= shreg_d;
            bit_cnt        <= bit_cnt_d;
            cmd_out_q      <= cmd_out_d;
            cmd_oe_q       <= cmd_oe_d;
            cmd_valid_q    <= cmd_valid_d;
            crc_error_q    <= crc_error_d;
            busy_q         <= busy_d;
            cmd_index_q    <= cmd_index_d;
            cmd_argument_q <= cmd_argument_d;
        end
    end

    always_comb begin
        state_d        = state;
        shreg_d        = shreg;
        bit_cnt_d      = bit_cnt;
        cmd_out_d      = 1'b1;
        cmd_oe_d       = 1'b0;
        cmd_valid_d    = 1'b0;
        crc_error_d    = 1'b0;
        cmd_index_d    = cmd_index_q;
        cmd_argument_d = cmd_argument_q;

        unique case (state)
            IDLE: begin
                if (!bus.cmd_in) begin
                    state_d   = RECV;
                    shreg_d   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = CNT_W'(1);
                end
            end
            RECV: begin
                if (bit_cnt != CNT_W'(FRAME_W)) begin
                    shreg_d   = {shreg[FRAME_W-2:0], bus.cmd_in};
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                end else begin
                    // Decision is registered so cmd_valid/crc_error are visible during CHECK
                    state_d   = CHECK;
                    bit_cnt_d = '0;
                    if (frame_ok_c) begin
                        cmd_valid_d    = 1'b1;
                        cmd_index_d    = shreg[45:40];
                        cmd_argument_d = shreg[39:8];
                        shreg_d        = resp_frame_c;
                    end else begin
                        crc_error_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = cmd_valid_q ? WAIT_NCR : IDLE;
            end
            WAIT_NCR: begin
                if (bit_cnt == CNT_W'(NCR - 1)) begin
                    state_d   = SEND;
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = shreg[FRAME_W-1];
                    shreg_d   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = CNT_W'(1);
                end else begin
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                end
            end
            SEND: begin
                if (bit_cnt == CNT_W'(FRAME_W)) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = shreg[FRAME_W-1];
                    shreg_d   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.cmd_out      = cmd_out_q;
    assign bus.cmd_oe       = cmd_oe_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.crc_error    = crc_error_q;
    assign bus.busy         = busy_q;
    assign bus.cmd_index    = cmd_index_q;
    assign bus.cmd_argument = cmd_argument_q;
endmodule
